vga_timing_gen: RTL and testbench

//  Generates 640x480@60 VGA sync and pixel-coordinate timing from the 100 MHz system clk.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-side and VGA-pin signal bundle for the timing generator
interface vga_timing_gen_if;
    // colour supplied by the pattern logic for the current coordinate
    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;
    // coordinate and strobe outputs towards the pattern logic
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_active;
    logic       pix_tick;
    logic       frame_start;
    // registered VGA pins
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    // timing generator side: owns the coordinates and the pins
    modport master (
        input  pix_r, pix_g, pix_b,
        output pix_x, pix_y, pix_active, pix_tick, frame_start,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

    // pattern logic / pin consumer side
    modport slave (
        output pix_r, pix_g, pix_b,
        input  pix_x, pix_y, pix_active, pix_tick, frame_start,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/coordinate timing with registered, blanked colour output
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_timing_gen_if.master       bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    // all coordinate comparisons are done at the 10-bit counter width
    localparam logic [9:0] LP_H_ACTIVE = 10'(H_ACTIVE);
    localparam logic [9:0] LP_H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] LP_H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] LP_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] LP_V_ACTIVE = 10'(V_ACTIVE);
    localparam logic [9:0] LP_V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] LP_V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] LP_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_pix_x;
    logic [9:0]       r_pix_y;
    logic             r_vga_hs;
    logic             r_vga_vs;
    logic [3:0]       r_vga_r;
    logic [3:0]       r_vga_g;
    logic [3:0]       r_vga_b;

    logic             w_tick;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_active;
    logic             w_hs_on;
    logic             w_vs_on;

    // the last divider phase is the pixel strobe; everything else advances on it
    assign w_tick   = (r_div_cnt == LP_DIV_LAST);
    assign w_x_last = (r_pix_x == LP_H_LAST);
    assign w_y_last = (r_pix_y == LP_V_LAST);
    assign w_active = (r_pix_x < LP_H_ACTIVE) && (r_pix_y < LP_V_ACTIVE);
    assign w_hs_on  = (r_pix_x >= LP_H_SYNC_S) && (r_pix_x < LP_H_SYNC_E);
    assign w_vs_on  = (r_pix_y >= LP_V_SYNC_S) && (r_pix_y < LP_V_SYNC_E);

    // clock divider producing one pixel slot every CLK_DIV clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // raster counters: x steps each pixel, y steps at end of line, both wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else if (w_tick) begin
            if (w_x_last) begin
                r_pix_x <= '0;
                r_pix_y <= w_y_last ? 10'd0 : r_pix_y + 10'd1;
            end else begin
                r_pix_x <= r_pix_x + 10'd1;
            end
        end
    end

    // pin stage: sync and blanked colour from the pre-increment coordinate, so all pins
    // lag the coordinate by exactly one pixel and stay aligned with each other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_hs <= ~SYNC_POL;
            r_vga_vs <= ~SYNC_POL;
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
        end else if (w_tick) begin
            r_vga_hs <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            r_vga_vs <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            r_vga_r  <= w_active ? bus.pix_r : 4'h0;
            r_vga_g  <= w_active ? bus.pix_g : 4'h0;
            r_vga_b  <= w_active ? bus.pix_b : 4'h0;
        end
    end

    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_active  = w_active;
    assign bus.pix_tick    = w_tick;
    assign bus.frame_start = w_tick && w_x_last && w_y_last;
    assign bus.vga_hs      = r_vga_hs;
    assign bus.vga_vs      = r_vga_vs;
    assign bus.vga_r       = r_vga_r;
    assign bus.vga_g       = r_vga_g;
    assign bus.vga_b       = r_vga_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of VGA timing at full and reduced geometry
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_full ();
    vga_timing_gen_if if_small ();

    // standard 640x480 geometry
    vga_timing_gen u_dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_full)
    );

    // reduced geometry: 15 x 8 pixel raster, 60 clks per line, 480 clks per frame
    vga_timing_gen #(
        .CLK_DIV (4),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_small)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [11:0] rgb);
        if_full.pix_r  = rgb[11:8];
        if_full.pix_g  = rgb[7:4];
        if_full.pix_b  = rgb[3:0];
        if_small.pix_r = rgb[11:8];
        if_small.pix_g = rgb[7:4];
        if_small.pix_b = rgb[3:0];
    endtask

    function automatic logic [11:0] small_rgb();
        return {if_small.vga_r, if_small.vga_g, if_small.vga_b};
    endfunction

    initial begin
        logic [7:0]  mask;
        logic [9:0]  x4;
        logic        ph;
        logic [11:0] prev_rgb;
        logic [11:0] cur_pix;
        logic [11:0] exp_rgb;
        logic        p_tick;
        logic        p_active;
        int t, tf1, tr, tf2, xf1, yf1;
        int nfs, fs1, fs2, fs_x, fs_y, wrap_x, wrap_y, vf, vr, vf_x, vf_y;
        int n_col, n_bad, n_sync_col, t_first, n_ticks;
        bit found;

        // ---- 1: reset values, then first 8 clocks after release
        set_pix(12'h000);
        repeat (3) step();
        check("rst_x",     32'(if_full.pix_x), 0);
        check("rst_y",     32'(if_full.pix_y), 0);
        check("rst_tick",  32'(if_full.pix_tick), 0);
        check("rst_fs",    32'(if_full.frame_start), 0);
        check("rst_hs",    32'(if_full.vga_hs), 1);
        check("rst_vs",    32'(if_full.vga_vs), 1);
        check("rst_rgb",   32'({if_full.vga_r, if_full.vga_g, if_full.vga_b}), 0);
        rst_n = 1'b1;
        mask = '0;
        x4 = '0;
        for (int k = 1; k <= 8; k++) begin
            mask[k-1] = if_full.pix_tick;
            step();
            if (k == 4) x4 = if_full.pix_x;
        end
        check("tick_mask", 32'(mask), 32'h88);
        check("x_after4",  32'(x4), 1);
        check("x_after8",  32'(if_full.pix_x), 2);
        check("hs_run8",   32'(if_full.vga_hs), 1);
        check("vs_run8",   32'(if_full.vga_vs), 1);
        check("rgb_run8",  32'({if_full.vga_r, if_full.vga_g, if_full.vga_b}), 0);

        // ---- 2: one full line on the standard geometry
        t = 0; tf1 = -1; tr = -1; tf2 = -1; xf1 = 0;
        ph = if_full.vga_hs;
        for (int i = 0; i < 8000 && tf2 < 0; i++) begin
            step();
            t++;
            if (ph && !if_full.vga_hs) begin
                if (tf1 < 0) begin
                    tf1 = t;
                    xf1 = int'(if_full.pix_x);
                end else begin
                    tf2 = t;
                end
            end
            if (!ph && if_full.vga_hs && tf1 >= 0 && tr < 0) tr = t;
            ph = if_full.vga_hs;
        end
        check("line_done",   32'(tf2 >= 0), 1);
        check("hs_fall_x",   32'(xf1), 657);
        check("hs_low_clks", 32'(tr - tf1), 384);
        check("line_period", 32'(tf2 - tf1), 3200);

        // ---- 3: one frame on the reduced geometry
        t = 0; nfs = 0; fs1 = -1; fs2 = -1; fs_x = 0; fs_y = 0; wrap_x = -1; wrap_y = -1;
        vf = -1; vr = -1; vf_x = 0; vf_y = 0;
        ph = if_small.vga_vs;
        for (int i = 0; i < 2000 && !(fs2 >= 0 && vr >= 0); i++) begin
            step();
            t++;
            if (nfs == 1 && wrap_x < 0) begin
                wrap_x = int'(if_small.pix_x);
                wrap_y = int'(if_small.pix_y);
            end
            if (if_small.frame_start) begin
                nfs++;
                if (nfs == 1) begin
                    fs1 = t;
                    fs_x = int'(if_small.pix_x);
                    fs_y = int'(if_small.pix_y);
                end else if (nfs == 2) begin
                    fs2 = t;
                end
            end
            if (ph && !if_small.vga_vs && vf < 0) begin
                vf = t;
                vf_x = int'(if_small.pix_x);
                vf_y = int'(if_small.pix_y);
            end
            if (!ph && if_small.vga_vs && vf >= 0 && vr < 0) vr = t;
            ph = if_small.vga_vs;
        end
        check("frame_done",   32'(fs2 >= 0 && vr >= 0), 1);
        check("fs_at_x",      32'(fs_x), 14);
        check("fs_at_y",      32'(fs_y), 7);
        check("wrap_x",       32'(wrap_x), 0);
        check("wrap_y",       32'(wrap_y), 0);
        check("frame_period", 32'(fs2 - fs1), 480);
        check("vs_fall_x",    32'(vf_x), 1);
        check("vs_fall_y",    32'(vf_y), 5);
        check("vs_low_clks",  32'(vr - vf), 120);

        // ---- 4: constant colour, blanking outside the active area
        set_pix(12'hA5F);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            found = if_small.frame_start;
        end
        check("fs_found", 32'(found), 1);
        step();
        n_col = 0; n_bad = 0; n_sync_col = 0; t_first = -1;
        for (int k = 1; k <= 480; k++) begin
            step();
            if (small_rgb() == 12'hA5F) n_col++;
            else if (small_rgb() != 12'h000) n_bad++;
            if (small_rgb() != 12'h000 && t_first < 0) t_first = k;
            if ((!if_small.vga_hs || !if_small.vga_vs) && small_rgb() != 12'h000) n_sync_col++;
        end
        check("colour_clks",   32'(n_col), 128);
        check("colour_other",  32'(n_bad), 0);
        check("colour_insync", 32'(n_sync_col), 0);
        check("first_colour",  32'(t_first), 4);

        // ---- 5: colour changing every clock is only taken on pix_tick
        n_bad = 0; n_ticks = 0;
        for (int k = 0; k < 480; k++) begin
            p_tick   = if_small.pix_tick;
            p_active = if_small.pix_active;
            prev_rgb = small_rgb();
            cur_pix  = 12'($urandom);
            set_pix(cur_pix);
            step();
            if (p_tick) begin
                n_ticks++;
                exp_rgb = p_active ? cur_pix : 12'h000;
                if (small_rgb() != exp_rgb) n_bad++;
            end else if (small_rgb() != prev_rgb) begin
                n_bad++;
            end
        end
        check("rgb_tick_only", 32'(n_bad), 0);
        check("rgb_tick_cnt",  32'(n_ticks), 120);

        // ---- 6: asynchronous reset in the middle of hsync and vsync
        set_pix(12'hFFF);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            found = (if_small.pix_x == 10'd12) && (if_small.pix_y == 10'd6);
        end
        check("pos_found", 32'(found), 1);
        check("pre_rst_hs", 32'(if_small.vga_hs), 0);
        check("pre_rst_vs", 32'(if_small.vga_vs), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_x",    32'(if_small.pix_x), 0);
        check("arst_y",    32'(if_small.pix_y), 0);
        check("arst_hs",   32'(if_small.vga_hs), 1);
        check("arst_vs",   32'(if_small.vga_vs), 1);
        check("arst_rgb",  32'(small_rgb()), 0);
        check("arst_tick", 32'(if_small.pix_tick), 0);
        check("arst_fx",   32'(if_full.pix_x), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("rel_tick", 32'(if_small.pix_tick), 1);
        check("rel_x0",   32'(if_small.pix_x), 0);
        step();
        check("rel_x1",   32'(if_small.pix_x), 1);
        check("rel_y1",   32'(if_small.pix_y), 0);
        check("rel_tick_off", 32'(if_small.pix_tick), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
